key_sched_rev: RTL and testbench
================================

KEY_SCHED_REV -- requirements
Module: key_sched_rev

Interface
REQ-001 SHALL have no parameters; AES-128 only, 11 round keys, Nr=10 fixed.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a reverse key sweep.
REQ-005 key_in  input  128  round-10 key (w[40..43], w[40] in bits [127:96]); sampled on accepted start.
REQ-006 key_out  output  128  current round key, same word order as key_in.
REQ-007 key_round  output  4  round index of key_out (10 down to 0).
REQ-008 key_valid  output  1  key_out/key_round valid.
REQ-009 key_ready  input  1  downstream accepts key_out when high together with key_valid.
REQ-010 busy  output  1  high from accepted start until the round-0 key is accepted.
REQ-011 done  output  1  one-cycle pulse after the round-0 key is accepted.

Function
REQ-012 SHALL implement states IDLE and EMIT only.
REQ-013 IDLE: start=1 -> load key_in into the key register, set round to 10, go to EMIT; key_valid=1 on the following cycle.
REQ-014 start SHALL be ignored in EMIT; it is not queued.
REQ-015 EMIT: key_valid=1; key_out and key_round SHALL hold stable while key_ready=0.
REQ-016 Handshake (key_valid & key_ready) with round>0 -> the next cycle presents the round-1 key; at most one key per cycle; full rate when key_ready is held high.
REQ-017 Step from round r key (a,b,c,d = words 0..3) to round r-1 key (a',b',c',d'): d'=d^c, c'=c^b, b'=b^a, a'=a^SubWord(RotWord(d'))^Rcon(r), all computed combinationally in one cycle.
REQ-018 RotWord: bytes [B0,B1,B2,B3] -> [B1,B2,B3,B0], B0 being the MS byte.
REQ-019 SubWord SHALL use four instances of the team's existing forward S-box block, one per byte.
REQ-020 Rcon(r), r=1..10: 01,02,04,08,10,20,40,80,1b,36 in the MS byte, zeros below; it is generated internally from the round register.
REQ-021 Handshake with round=0 -> next cycle: key_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
REQ-022 start asserted in the cycle done is high SHALL be accepted (state is IDLE).
REQ-023 A sweep SHALL emit exactly 11 keys, rounds 10,9,...,0, with no skipped or repeated round.
REQ-024 key_out in IDLE SHALL retain the last emitted key; consumers qualify it with key_valid.
REQ-025 busy SHALL be high in EMIT only; busy and done are never both high.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, key_out=0, key_round=0, key_valid=0, busy=0, done=0, regardless of the current state.
REQ-027 Reset mid-sweep SHALL abort the sweep; no further key is emitted and no done pulse occurs; a new start after rst deasserts begins a fresh sweep.

Verification
REQ-028 FIPS-197 A.1: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> cycle+1: round 10 = key_in; cycle+2: round 9 = ac7766f319fadc2128d12941575c006e; cycle+11: round 0 = 2b7e151628aed2a6abf7158809cf4f3c; cycle+12: done=1.
REQ-029 Backpressure: same vector, key_ready toggled at random -> identical 11-key sequence; key_out/key_round stable in every valid & !ready cycle.
REQ-030 Restart: start pulsed during EMIT at round 5 -> ignored, sweep completes normally; start in the done cycle -> new sweep begins, round 10 valid on the next cycle.
REQ-031 Reset mid-sweep: rst at round 4 -> all outputs 0 the same cycle, no done pulse; a later start produces a full correct sequence.
REQ-032 Round trip: random 128-bit keys expanded by the forward key schedule; round-10 key fed in -> emitted keys match the forward round keys 10..0 exactly.

Source files
------------

// File: rtl/key_sched_rev.sv
// ---------------------------------------------------------------------------
// key_sched_rev -- AES-128 reverse key schedule sweeper.
//
// Given the round-10 key, emits the round keys 10, 9, ..., 0 one per accepted
// handshake. Each step back is computed combinationally in a single cycle.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle request to begin a sweep (accepted only in IDLE)
//   key_in     round-10 key, w[40] in [127:96]; sampled on accepted start
//   key_out    current round key, same word order as key_in
//   key_round  round index of key_out (10 down to 0)
//   key_valid  key_out/key_round valid
//   key_ready  downstream accepts key_out when high together with key_valid
//   busy       high while a sweep is in progress (EMIT state)
//   done       one-cycle pulse after the round-0 key is accepted
//
// Handshake: a key transfers on every rising edge where key_valid and
// key_ready are both high. While key_valid is high and key_ready is low,
// key_out and key_round hold. key_valid never drops before a transfer.
// ---------------------------------------------------------------------------

// Forward AES S-box. The multiplicative inverse in GF(2^8) is formed as
// x^254 with an addition chain, followed by the FIPS-197 affine transform.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    always_comb begin
        // 254 = 240 + 12 + 2; zero maps to zero, as the S-box requires.
        x2   = gf_mul(din, din);
        x3   = gf_mul(x2, din);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        dout = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    end

endmodule

module key_sched_rev (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [3:0]   round_reg;
    logic         done_reg;

    logic         load_key;
    logic         step_key;
    logic         done_next;

    // ------------------------------------------------------------------
    // One step backwards through the key expansion.
    // ------------------------------------------------------------------
    logic [31:0]  wa, wb, wc, wd;
    logic [31:0]  na, nb, nc, nd;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [127:0] key_prev;

    assign wa = key_reg[127:96];
    assign wb = key_reg[95:64];
    assign wc = key_reg[63:32];
    assign wd = key_reg[31:0];

    assign nd = wd ^ wc;
    assign nc = wc ^ wb;
    assign nb = wb ^ wa;

    // RotWord of the recovered last word: MS byte moves to the LS position.
    assign rot_word = {nd[23:0], nd[31:24]};

    aes_sbox u_sbox3 (.din(rot_word[31:24]), .dout(sub_word[31:24]));
    aes_sbox u_sbox2 (.din(rot_word[23:16]), .dout(sub_word[23:16]));
    aes_sbox u_sbox1 (.din(rot_word[15:8]),  .dout(sub_word[15:8]));
    aes_sbox u_sbox0 (.din(rot_word[7:0]),   .dout(sub_word[7:0]));

    // Rcon of the round being stepped out of; round 0 is never stepped.
    always_comb begin
        rcon = 8'h00;
        case (round_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign na       = wa ^ sub_word ^ {rcon, 24'h000000};
    assign key_prev = {na, nb, nc, nd};

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath enables.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load_key   = 1'b0;
        step_key   = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_key   = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                // start is deliberately not looked at here: it is dropped,
                // not queued.
                if (key_ready) begin
                    if (round_reg == 4'd0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        step_key = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Key and round registers keep their value in IDLE, so the last emitted
    // key stays visible after a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg   <= 128'h0;
            round_reg <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= done_next;
            if (load_key) begin
                key_reg   <= key_in;
                round_reg <= 4'd10;
            end else if (step_key) begin
                key_reg   <= key_prev;
                round_reg <= round_reg - 4'd1;
            end
        end
    end

    assign key_out   = key_reg;
    assign key_round = round_reg;
    assign key_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign done      = done_reg;

endmodule

// File: tb/tb_key_sched_rev.sv
// Bench for key_sched_rev: FIPS-197 A.1 table sweep, backpressure, ignored
// start, restart from the done cycle, mid-sweep reset and random round trips
// against an independently built forward key expansion.
module tb_key_sched_rev;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  logic [7:0]   rcon_t[11];
  vec_t         fips[11];

  key_sched_rev dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key_in(key_in),
    .key_out(key_out),
    .key_round(key_round),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .busy(busy),
    .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box table from the generator/inverse-generator walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Forward key expansion; pushes rounds 10..0 into the expected queue.
  task automatic expand_and_push(input logic [127:0] k, output logic [127:0] k10);
    logic [31:0] w[44];
    logic [31:0] t;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_w({t[23:0], t[31:24]}) ^ {rcon_t[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    end
    k10 = {w[40], w[41], w[42], w[43]};
  endtask

  task automatic push_fips();
    for (int i = 0; i < 11; i++) exp_q.push_back({fips[i].round, fips[i].key});
  endtask

  // driver + scoreboard for one full sweep; entered and left on a negedge
  task automatic run_sweep(input logic [127:0] k, input bit random_ready,
                           input bit poke5, input bit restart);
    bit           held;
    bit           last;
    bit           poked;
    bit           rdy;
    int           cyc;
    int           n;
    logic [131:0] hold_v;
    logic [131:0] e;
    held  = 0;
    last  = 0;
    poked = 0;
    cyc   = 0;
    key_in    = k;
    start     = 1'b1;
    key_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("valid_after_start", 132'(key_valid), 132'(1));
    while (!last && cyc < 300) begin
      if (held) check("hold_stable", {key_round, key_out}, hold_v);
      held = 0;
      check("valid_in_sweep", 132'({key_valid, busy, done}), 132'(3'b110));
      if (poke5 && !poked && key_round == 4'd5) begin
        start  = 1'b1;
        key_in = ~k;
        poked  = 1;
      end
      rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      key_ready = rdy;
      if (key_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_key", {key_round, key_out}, 132'(0));
        end else begin
          e = exp_q.pop_front();
          check("key_seq", {key_round, key_out}, e);
        end
        if (key_round == 4'd0) last = 1;
      end else if (key_valid) begin
        held   = 1;
        hold_v = {key_round, key_out};
      end
      @(negedge clk);
      start  = 1'b0;
      key_in = k;
      cyc++;
    end
    if (!last) check("sweep_timeout", 132'(0), 132'(1));
    check("done_pulse", 132'({done, busy, key_valid}), 132'(3'b100));
    check("queue_empty", 132'(exp_q.size()), 132'(0));
    exp_q.delete();
    key_ready = 1'b0;
    if (restart) begin
      start  = 1'b1;
      key_in = k;
      @(negedge clk);
      start = 1'b0;
      check("restart_first", {key_valid, done, key_round, key_out}, {1'b1, 1'b0, 4'd10, k});
      key_ready = 1'b1;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("restart_len", 132'(n), 132'(11));
      key_ready = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", 132'(done), 132'(0));
  endtask

  initial begin
    logic [127:0] k10;
    logic [127:0] rk;
    int           n;
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    start     = 1'b0;
    key_in    = '0;
    key_ready = 1'b0;

    build_sbox();
    rcon_t[0]  = 8'h00; rcon_t[1] = 8'h01; rcon_t[2] = 8'h02; rcon_t[3] = 8'h04;
    rcon_t[4]  = 8'h08; rcon_t[5] = 8'h10; rcon_t[6] = 8'h20; rcon_t[7] = 8'h40;
    rcon_t[8]  = 8'h80; rcon_t[9] = 8'h1b; rcon_t[10] = 8'h36;

    fips[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    fips[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {key_out, key_round}, 132'(0));
    check("reset_flags", 132'({key_valid, busy, done}), 132'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_flags", 132'({key_valid, busy, done}), 132'(0));

    // FIPS-197 A.1, full rate
    push_fips();
    run_sweep(fips[0].key, 0, 0, 0);
    check("idle_retains_round0", {key_round, key_out}, {fips[10].round, fips[10].key});

    // FIPS-197 A.1, random backpressure
    push_fips();
    run_sweep(fips[0].key, 1, 0, 0);

    // start during EMIT ignored, then restart in the done cycle
    push_fips();
    run_sweep(fips[0].key, 1, 1, 1);

    // reset at round 4
    key_in    = fips[0].key;
    start     = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (key_round != 4'd4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reach_round4", 132'(key_round), 132'(4));
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {key_out, key_round}, 132'(0));
    check("rst_mid_flags", 132'({key_valid, busy, done}), 132'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 132'({key_valid, busy, done}), 132'(0));
    end
    key_ready = 1'b0;
    push_fips();
    run_sweep(fips[0].key, 1, 0, 0);

    // round trips from random cipher keys
    for (int t = 0; t < 3; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      expand_and_push(rk, k10);
      run_sweep(k10, 1, 0, 0);
      check("roundtrip_key0", key_out, rk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
